player_missile_ctrl: RTL
========================

PLAYER_MISSILE_CTRL -- requirements
Module: player_missile_ctrl

Interface
REQ-001 Parameters SHALL be: MISSILE_SPEED, default 256, upward step per frame in 1/64 px (4 px/frame); MISSILE_TOP_Y, default 16, top screen limit in px; PLAYER_WIDTH, default 64, player sprite width in px; MISSILE_WIDTH, default 4, px; MISSILE_HEIGHT, default 16, px; COOLDOWN_FRAMES, default 15, frames.
REQ-002 Ports SHALL be:
- clk  in  1  clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse per frame
- playGame  in  1  game running; low = synchronous clear
- enter  in  1  fire key, level
- playerTopLeftX  in  11 signed  player position from player movement stage
- playerTopLeftY  in  11 signed  player position from player movement stage
- missileHitAlien  in  1  collision with alien
- missileHitShield  in  1  collision with shield
- missileTopLeftX  out  11 signed  missile position, px
- missileTopLeftY  out  11 signed  missile position, px
- missileActive  out  1  missile drawn and collidable
- shotFired  out  1  one-cycle pulse on launch

Function
REQ-003 The fire press SHALL be the rising edge of enter (enter high, registered previous value low); a held key SHALL fire once only.
REQ-004 FSM states SHALL be READY, FLYING, COOLDOWN.
REQ-005 In READY, a press SHALL latch X = playerTopLeftX + PLAYER_WIDTH/2 - MISSILE_WIDTH/2 and Y_fp = (playerTopLeftY - MISSILE_HEIGHT)*64, then enter FLYING on the next edge.
REQ-006 On that same edge, missileActive SHALL rise and shotFired SHALL pulse high for exactly one cycle.
REQ-007 In FLYING, each startOfFrame SHALL subtract MISSILE_SPEED from Y_fp; X SHALL stay constant regardless of later player motion.
REQ-008 missileTopLeftY SHALL equal Y_fp arithmetically shifted right by 6 (floor); Y_fp SHALL be a 32-bit signed value.
REQ-009 In FLYING, if the updated integer Y is <= MISSILE_TOP_Y, the block SHALL enter COOLDOWN and drop missileActive on the same edge.
REQ-010 In FLYING, missileHitAlien or missileHitShield high SHALL cause COOLDOWN and drop missileActive on the next edge.
REQ-011 A hit coinciding with startOfFrame SHALL take priority; Y SHALL not be updated.
REQ-012 In COOLDOWN, a counter loaded with COOLDOWN_FRAMES SHALL decrement on each startOfFrame; at 0, the state SHALL return to READY.
REQ-013 Presses during FLYING or COOLDOWN SHALL be ignored and not queued.
REQ-014 Hit inputs SHALL be ignored outside FLYING.
REQ-015 While missileActive is low, position outputs SHALL hold their last values.

Reset
REQ-016 Asserting resetN low SHALL immediately force READY, missileActive=0, shotFired=0, positions=0, cooldown counter=0, and the edge register=1, so a key already held at release does not fire.
REQ-017 playGame low SHALL give the same result as REQ-016 on the next clk edge, including mid-flight or mid-cooldown.

Configuration
REQ-018 With PLAYER_MISSILE_COOLDOWN_EN defined, COOLDOWN SHALL operate as in REQ-012.
REQ-019 Without PLAYER_MISSILE_COOLDOWN_EN, FLYING exit SHALL go directly to READY, and the counter SHALL not be synthesised.

Structure
REQ-020 Package player_missile_pkg SHALL hold FIXED_POINT_MULTIPLIER (64), FIXED_SHIFT (6), and the missile_state_t enum.
REQ-021 Rising-edge detection SHALL be the sub-module rise_edge_detect (clk, resetN, in, pulse).

Verification
REQ-022 Fire: player (240,420), pulse enter -> X=270, Y=404, missileActive=1, shotFired high 1 cycle.
REQ-023 Flight: 10 startOfFrame pulses after launch -> Y=364; player moves to X=400 -> missile X stays 270.
REQ-024 Top exit: 97 frames after launch -> Y=16, missileActive=0; with macro, 15 further frames -> READY, and a press then fires.
REQ-025 Hit priority: missileHitAlien and startOfFrame in the same cycle at Y=300 -> Y stays 300, missileActive=0 next cycle; enter held throughout -> no second shot.
REQ-026 Abort: playGame low mid-flight -> next cycle missileActive=0, state READY; resetN low -> outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/player_missile_pkg.sv
// Shared constants and state type for the player missile block.
// Fixed-point Y uses 6 fractional bits (1/64 px).
package player_missile_pkg;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FIXED_SHIFT = 6;

  typedef enum logic [1:0] {
    READY,
    FLYING,
    COOLDOWN
  } missile_state_t;

endpackage

// File: rtl/player_missile_if.sv
// Missile bus: position/status out of the controller, collisions in.
// master = missile controller, slave = renderer / collision logic.
interface player_missile_if;

  logic signed [10:0] missileTopLeftX;
  logic signed [10:0] missileTopLeftY;
  logic               missileActive;
  logic               shotFired;
  logic               missileHitAlien;
  logic               missileHitShield;

  modport master (
    output missileTopLeftX,
    output missileTopLeftY,
    output missileActive,
    output shotFired,
    input  missileHitAlien,
    input  missileHitShield
  );

  modport slave (
    input  missileTopLeftX,
    input  missileTopLeftY,
    input  missileActive,
    input  shotFired,
    output missileHitAlien,
    output missileHitShield
  );

endinterface

// File: rtl/rise_edge_detect.sv
// Rising-edge detector; history resets high so a level held
// through reset release does not produce a pulse.
module rise_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = in;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) prev_q <= 1'b1;
    else         prev_q <= prev_d;
  end

  assign pulse = in & ~prev_q;

endmodule

// File: rtl/player_missile_ctrl.sv
// Player missile: launch, fixed-point upward flight, hit/top exit.
// Define PLAYER_MISSILE_COOLDOWN_EN to enable the post-flight cooldown.
module player_missile_ctrl
  import player_missile_pkg::*;
#(
  parameter int MISSILE_SPEED   = 256,
  parameter int MISSILE_TOP_Y   = 16,
  parameter int PLAYER_WIDTH    = 64,
  parameter int MISSILE_WIDTH   = 4,
  parameter int MISSILE_HEIGHT  = 16,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               playGame,
  input  logic               enter,
  input  logic signed [10:0] playerTopLeftX,
  input  logic signed [10:0] playerTopLeftY,
  player_missile_if.master   bus
);

  localparam logic signed [10:0] X_OFS =
    11'(PLAYER_WIDTH / 2 - MISSILE_WIDTH / 2);

  missile_state_t     state_q, state_d;
  logic signed [31:0] y_fp_q, y_fp_d;
  logic signed [10:0] x_q, x_d;
  logic               active_q, active_d;
  logic               shot_q, shot_d;

  logic               fire;
  logic               hit;
  logic               leave;
  logic               exit_top;
  logic signed [31:0] y_step;
  logic signed [31:0] y_launch;
  logic signed [10:0] x_launch;

`ifdef PLAYER_MISSILE_COOLDOWN_EN
  localparam int CW = $clog2(COOLDOWN_FRAMES + 2);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Forcing the detector input high while idle keeps a held key
  // from firing when the game (re)starts.
  rise_edge_detect u_edge (
    .clk   (clk),
    .resetN(resetN),
    .in    (enter | ~playGame),
    .pulse (fire)
  );

  assign hit      = bus.missileHitAlien | bus.missileHitShield;
  assign y_step   = y_fp_q - MISSILE_SPEED;
  assign exit_top = (y_step >>> FIXED_SHIFT) <= MISSILE_TOP_Y;
  assign x_launch = playerTopLeftX + X_OFS;
  assign y_launch = (32'(playerTopLeftY) - MISSILE_HEIGHT)
                  * FIXED_POINT_MULTIPLIER;

  always_comb begin
    state_d  = state_q;
    y_fp_d   = y_fp_q;
    x_d      = x_q;
    active_d = active_q;
    shot_d   = 1'b0;
    leave    = 1'b0;
`ifdef PLAYER_MISSILE_COOLDOWN_EN
    cnt_d    = cnt_q;
`endif
    if (!playGame) begin
      state_d  = READY;
      y_fp_d   = '0;
      x_d      = '0;
      active_d = 1'b0;
`ifdef PLAYER_MISSILE_COOLDOWN_EN
      cnt_d    = '0;
`endif
    end else begin
      unique case (state_q)
        READY: begin
          if (fire) begin
            x_d      = x_launch;
            y_fp_d   = y_launch;
            active_d = 1'b1;
            shot_d   = 1'b1;
            state_d  = FLYING;
          end
        end
        FLYING: begin
          // A hit freezes Y even when it lands on a frame tick.
          if (hit) begin
            leave = 1'b1;
          end else if (startOfFrame) begin
            y_fp_d = y_step;
            leave  = exit_top;
          end
        end
        COOLDOWN: begin
`ifdef PLAYER_MISSILE_COOLDOWN_EN
          if (startOfFrame) begin
            if (cnt_q <= CW'(1)) begin
              cnt_d   = '0;
              state_d = READY;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
`else
          state_d = READY;
`endif
        end
        default: state_d = READY;
      endcase
      if (leave) begin
        active_d = 1'b0;
`ifdef PLAYER_MISSILE_COOLDOWN_EN
        state_d  = COOLDOWN;
        cnt_d    = CW'(COOLDOWN_FRAMES);
`else
        state_d  = READY;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= READY;
      y_fp_q   <= '0;
      x_q      <= '0;
      active_q <= 1'b0;
      shot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_fp_q   <= y_fp_d;
      x_q      <= x_d;
      active_q <= active_d;
      shot_q   <= shot_d;
    end
  end

`ifdef PLAYER_MISSILE_COOLDOWN_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

  assign bus.missileTopLeftX = x_q;
  assign bus.missileTopLeftY = 11'(y_fp_q >>> FIXED_SHIFT);
  assign bus.missileActive   = active_q;
  assign bus.shotFired       = shot_q;

endmodule
